// File: rtl/ofdm_rx_pkg.sv
// Shared types and size defaults for the OFDM receive front end.
package ofdm_rx_pkg;

  localparam int NFFT_MAX_DEFAULT = 4096;
  localparam int CP_MAX_DEFAULT   = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CP   = 2'd1,
    DATA = 2'd2
  } cp_rm_state_t;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] i;
  } iq_sample_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream buffer: registered output and a ready that never depends
// combinationally on out_ready, while still sustaining one beat per cycle.
module axis_skid_buffer #(
  parameter int WIDTH = 34
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             wr_s;
  logic             rd_s;

  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign out_data  = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign wr_s      = in_valid & in_ready;
  assign rd_s      = out_valid & out_ready;

  // Storage, pointers and occupancy
  always_ff @(posedge aclk) begin
    if (areset) begin
      mem_r[0] <= {WIDTH{1'b0}};
      mem_r[1] <= {WIDTH{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= in_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_r + {1'b0, wr_s} - {1'b0, rd_s};
    end
  end

endmodule

// File: rtl/ofdm_cp_remover.sv
// OFDM receive deframer: drops the cyclic prefix of each symbol and forwards the
// useful samples as tlast-terminated packets. CP_REMOVER_OUTREG_EN adds an output skid buffer.
module ofdm_cp_remover
  import ofdm_rx_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NFFT_MAX = NFFT_MAX_DEFAULT,
  parameter int CP_MAX   = CP_MAX_DEFAULT,
  parameter int NFFT_W   = $clog2(NFFT_MAX + 1),
  parameter int CP_W     = $clog2(CP_MAX + 1)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [NFFT_W-1:0] cfg_nfft,
  input  logic [CP_W-1:0]   cfg_cp_len,
  input  logic [15:0]       cfg_num_symbols,
  input  logic              start,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              busy,
  output logic [15:0]       symbol_idx,
  output logic              done
);

  localparam int CNT_W = (NFFT_W > CP_W) ? NFFT_W : CP_W;

  cp_rm_state_t     state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] nfft_r;
  logic [CNT_W-1:0] cp_len_r;
  logic [15:0]      num_sym_r;
  logic [15:0]      symbol_idx_r;
  logic             busy_r;
  logic             done_r;

  logic in_data_s;
  logic in_hs_s;
  logic cp_last_s;
  logic data_last_s;
  logic frame_last_s;
  logic final_in_s;
  logic start_ok_s;
  logic fwd_ready_s;
  logic tlast_s;
  logic tuser_s;

  assign in_data_s    = (state_r == DATA);
  assign in_hs_s      = s_axis_tvalid & s_axis_tready;
  assign cp_last_s    = (cnt_r == cp_len_r - CNT_W'(1));
  assign data_last_s  = (cnt_r == nfft_r - CNT_W'(1));
  assign frame_last_s = (symbol_idx_r == num_sym_r - 16'd1);
  assign final_in_s   = in_data_s & in_hs_s & data_last_s & frame_last_s;
  assign start_ok_s   = start & (cfg_nfft != NFFT_W'(0)) & (cfg_num_symbols != 16'd0);
  assign tlast_s      = in_data_s & data_last_s;
  assign tuser_s      = in_data_s & (cnt_r == CNT_W'(0)) & (symbol_idx_r == 16'd0);

  // CP and IDLE always accept; only DATA inherits downstream backpressure
  assign s_axis_tready = in_data_s ? fwd_ready_s : 1'b1;
  assign busy          = busy_r;
  assign symbol_idx    = symbol_idx_r;
  assign done          = done_r;

  // Frame sequencing: state, per-symbol sample counter and symbol index
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_W'(0);
      nfft_r       <= CNT_W'(0);
      cp_len_r     <= CNT_W'(0);
      num_sym_r    <= 16'd0;
      symbol_idx_r <= 16'd0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            nfft_r       <= CNT_W'(cfg_nfft);
            cp_len_r     <= CNT_W'(cfg_cp_len);
            num_sym_r    <= cfg_num_symbols;
            cnt_r        <= CNT_W'(0);
            symbol_idx_r <= 16'd0;
            busy_r       <= 1'b1;
            state_r      <= (cfg_cp_len == CP_W'(0)) ? DATA : CP;
          end else begin
            state_r <= IDLE;
          end
        end
        CP: begin
          if (in_hs_s) begin
            if (cp_last_s) begin
              cnt_r   <= CNT_W'(0);
              state_r <= DATA;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end else begin
            state_r <= CP;
          end
        end
        DATA: begin
          if (in_hs_s) begin
            if (data_last_s) begin
              cnt_r <= CNT_W'(0);
              if (frame_last_s) begin
                symbol_idx_r <= 16'd0;
                busy_r       <= 1'b0;
                state_r      <= IDLE;
              end else begin
                symbol_idx_r <= symbol_idx_r + 16'd1;
                state_r      <= (cp_len_r == CNT_W'(0)) ? DATA : CP;
              end
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end else begin
            state_r <= DATA;
          end
        end
        default: begin
          state_r      <= IDLE;
          cnt_r        <= CNT_W'(0);
          symbol_idx_r <= 16'd0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

`ifdef CP_REMOVER_OUTREG_EN
  logic [1:0] buf_count_s;
  logic [1:0] fin_pos_r;
  logic       buf_out_hs_s;

  axis_skid_buffer #(
    .WIDTH(DATA_W + 2)
  ) u_skid (
    .aclk      (aclk),
    .areset    (areset),
    .in_data   ({tuser_s, tlast_s, s_axis_tdata}),
    .in_valid  (in_data_s & s_axis_tvalid),
    .in_ready  (fwd_ready_s),
    .out_data  ({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .count     (buf_count_s)
  );

  assign buf_out_hs_s = m_axis_tvalid & m_axis_tready;

  // fin_pos_r is the buffer position of the frame's final sample; done fires once it drains
  always_ff @(posedge aclk) begin
    if (areset) begin
      fin_pos_r <= 2'd0;
      done_r    <= 1'b0;
    end else if (final_in_s) begin
      fin_pos_r <= buf_count_s + 2'd1 - {1'b0, buf_out_hs_s};
      done_r    <= 1'b0;
    end else if ((fin_pos_r != 2'd0) && buf_out_hs_s) begin
      fin_pos_r <= fin_pos_r - 2'd1;
      done_r    <= (fin_pos_r == 2'd1);
    end else begin
      done_r <= 1'b0;
    end
  end
`else
  assign fwd_ready_s   = m_axis_tready;
  assign m_axis_tvalid = in_data_s & s_axis_tvalid;
  assign m_axis_tdata  = in_data_s ? s_axis_tdata : {DATA_W{1'b0}};
  assign m_axis_tlast  = tlast_s;
  assign m_axis_tuser  = tuser_s;

  // End-of-frame pulse, one cycle after the final useful sample is accepted
  always_ff @(posedge aclk) begin
    if (areset) begin
      done_r <= 1'b0;
    end else begin
      done_r <= final_in_s;
    end
  end
`endif

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Self-checking bench for ofdm_cp_remover (pass-through build) against a frame-arithmetic model.
module tb_ofdm_cp_remover;

  localparam int DATA_W = 32;
  localparam int NFFT_W = 13;
  localparam int CP_W   = 11;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [NFFT_W-1:0] cfg_nfft = '0;
  logic [CP_W-1:0]   cfg_cp_len = '0;
  logic [15:0]       cfg_num_symbols = '0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;
  logic              m_axis_tuser;
  logic              busy;
  logic [15:0]       symbol_idx;
  logic              done;

  ofdm_cp_remover #(
    .DATA_W(DATA_W), .NFFT_MAX(4096), .CP_MAX(1024), .NFFT_W(NFFT_W), .CP_W(CP_W)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cfg_nfft(cfg_nfft), .cfg_cp_len(cfg_cp_len), .cfg_num_symbols(cfg_num_symbols),
    .start(start),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy(busy), .symbol_idx(symbol_idx), .done(done)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  // Reference model: position within the frame measured in accepted input samples
  bit m_active   = 1'b0;
  bit m_done_exp = 1'b0;
  int m_k = 0, m_nfft = 1, m_cp = 0, m_nsym = 1;

  int n_out, n_last, n_user, n_done;
  logic [31:0] out_log[$];

  task automatic cycle(input logic st, input logic sv, input logic [31:0] sd,
                       input logic mr, output logic hs);
    int per, pos, sym;
    logic dph, exp_rdy;
    logic [15:0] exp_si;
    @(posedge aclk); #1;
    start = st; s_axis_tvalid = sv; s_axis_tdata = sd; m_axis_tready = mr;
    @(negedge aclk);
    per = m_nfft + m_cp;
    pos = m_active ? (m_k % per) : 0;
    sym = m_active ? (m_k / per) : 0;
    dph = m_active && (pos >= m_cp);
    exp_rdy = dph ? mr : 1'b1;
    exp_si = 16'(sym);
    total++;
    if (s_axis_tready !== exp_rdy) begin
      bad++; $display("FAIL s_tready k=%0d got=%b exp=%b", m_k, s_axis_tready, exp_rdy);
    end
    total++;
    if (busy !== m_active) begin
      bad++; $display("FAIL busy k=%0d got=%b exp=%b", m_k, busy, m_active);
    end
    total++;
    if (symbol_idx !== exp_si) begin
      bad++; $display("FAIL symbol_idx k=%0d got=%0d exp=%0d", m_k, symbol_idx, exp_si);
    end
    total++;
    if (done !== m_done_exp) begin
      bad++; $display("FAIL done k=%0d got=%b exp=%b", m_k, done, m_done_exp);
    end
    total++;
    if (m_axis_tvalid !== (dph & sv)) begin
      bad++; $display("FAIL m_tvalid k=%0d got=%b exp=%b", m_k, m_axis_tvalid, dph & sv);
    end
    if (dph && sv && mr) begin
      n_out++;
      out_log.push_back(m_axis_tdata);
      total++;
      if (m_axis_tdata !== sd) begin
        bad++; $display("FAIL m_tdata k=%0d got=%h exp=%h", m_k, m_axis_tdata, sd);
      end
      total++;
      if (m_axis_tlast !== (pos == per - 1)) begin
        bad++; $display("FAIL m_tlast k=%0d got=%b exp=%b", m_k, m_axis_tlast, pos == per - 1);
      end
      total++;
      if (m_axis_tuser !== (sym == 0 && pos == m_cp)) begin
        bad++; $display("FAIL m_tuser k=%0d got=%b exp=%b", m_k, m_axis_tuser, sym == 0 && pos == m_cp);
      end
      if (m_axis_tlast === 1'b1) n_last++;
      if (m_axis_tuser === 1'b1) n_user++;
    end
    if (done === 1'b1) n_done++;
    hs = sv & exp_rdy;
    m_done_exp = 1'b0;
    if (m_active) begin
      if (hs) begin
        m_k++;
        if (m_k == per * m_nsym) begin
          m_active = 1'b0;
          m_done_exp = 1'b1;
        end
      end
    end else if (st && cfg_nfft != 0 && cfg_num_symbols != 0) begin
      m_nfft = int'(cfg_nfft); m_cp = int'(cfg_cp_len); m_nsym = int'(cfg_num_symbols);
      m_active = 1'b1; m_k = 0;
    end
  endtask

  task automatic clear_counts();
    n_out = 0; n_last = 0; n_user = 0; n_done = 0;
    out_log.delete();
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    areset = 1'b1; start = 1'b0;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    m_active = 1'b0; m_done_exp = 1'b0; m_k = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0) begin
      bad++; $display("FAIL %s_flags got v=%b l=%b u=%b exp 000", tag, m_axis_tvalid, m_axis_tlast, m_axis_tuser);
    end
    total++;
    if (m_axis_tdata !== 32'h0) begin
      bad++; $display("FAIL %s_tdata got=%h exp=0", tag, m_axis_tdata);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || symbol_idx !== 16'd0) begin
      bad++; $display("FAIL %s_status got busy=%b done=%b sidx=%0d exp 0/0/0", tag, busy, done, symbol_idx);
    end
    total++;
    if (s_axis_tready !== 1'b1) begin
      bad++; $display("FAIL %s_s_tready got=%b exp=1", tag, s_axis_tready);
    end
  endtask

  // Starts a frame and runs it until the model has seen done, or until stop_k samples are accepted
  task automatic run_frame(input int nf, input int cp, input int ns, input int vpct, input int rpct,
                           input bit ramp, input int mid_start_k, input int stop_k, output bit finished);
    logic hs;
    logic [31:0] d;
    logic sv, mr;
    cfg_nfft = NFFT_W'(nf); cfg_cp_len = CP_W'(cp); cfg_num_symbols = 16'(ns);
    clear_counts();
    finished = 1'b0;
    cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, hs);
    d = ramp ? 32'd0 : $urandom;
    for (int c = 0; c < 20000; c++) begin
      if (stop_k >= 0 && m_active && m_k >= stop_k) break;
      sv = ($urandom_range(99) < vpct);
      mr = ($urandom_range(99) < rpct);
      cycle(m_active && (m_k == mid_start_k), sv, d, mr, hs);
      if (hs) d = ramp ? d + 32'd1 : $urandom;
      if (!m_active && !m_done_exp) begin
        finished = 1'b1;
        break;
      end
    end
    if (stop_k < 0) begin
      total++;
      if (!finished) begin
        bad++; $display("FAIL frame_timeout nfft=%0d cp=%0d got unfinished exp done", nf, cp);
      end
    end
  endtask

  task automatic check_frame_counts(input string tag, input int exp_out, input int exp_last);
    total++;
    if (n_out != exp_out) begin
      bad++; $display("FAIL %s_count got=%0d exp=%0d", tag, n_out, exp_out);
    end
    total++;
    if (n_last != exp_last || n_user != 1 || n_done != 1) begin
      bad++; $display("FAIL %s_markers got last=%0d user=%0d done=%0d exp %0d/1/1", tag, n_last, n_user, n_done, exp_last);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_outputs("reset");
  endtask

  task automatic test_basic();
    bit fin;
    run_frame(8, 2, 2, 100, 100, 1'b1, -1, -1, fin);
    check_frame_counts("basic", 16, 2);
    for (int i = 0; i < out_log.size(); i++) begin
      total++;
      if (out_log[i] !== ((i < 8) ? 32'(i + 2) : 32'(i + 4))) begin
        bad++; $display("FAIL basic_seq[%0d] got=%0d exp=%0d", i, out_log[i], (i < 8) ? i + 2 : i + 4);
      end
    end
  endtask

  task automatic test_large();
    bit fin;
    run_frame(4096, 256, 2, 100, 100, 1'b0, -1, -1, fin);
    check_frame_counts("large", 8192, 2);
  endtask

  task automatic test_cp_zero();
    bit fin;
    run_frame(4, 0, 3, 90, 50, 1'b1, -1, -1, fin);
    check_frame_counts("cp0", 12, 3);
    for (int i = 0; i < out_log.size(); i++) begin
      total++;
      if (out_log[i] !== 32'(i)) begin
        bad++; $display("FAIL cp0_seq[%0d] got=%0d exp=%0d", i, out_log[i], i);
      end
    end
  endtask

  task automatic test_backpressure();
    bit fin;
    run_frame(8, 2, 2, 80, 50, 1'b1, -1, -1, fin);
    check_frame_counts("bp", 16, 2);
    for (int i = 0; i < out_log.size(); i++) begin
      total++;
      if (out_log[i] !== ((i < 8) ? 32'(i + 2) : 32'(i + 4))) begin
        bad++; $display("FAIL bp_seq[%0d] got=%0d exp=%0d", i, out_log[i], (i < 8) ? i + 2 : i + 4);
      end
    end
  endtask

  task automatic test_midstart_reset();
    bit fin;
    // start at accepted sample 5 must be ignored; reset lands in symbol 1 DATA (sample 15)
    run_frame(8, 2, 3, 100, 100, 1'b1, 5, 15, fin);
    total++;
    if (n_out != 11 || n_last != 1) begin
      bad++; $display("FAIL midstart_progress got out=%0d last=%0d exp 11/1", n_out, n_last);
    end
    do_reset();
    check_reset_outputs("midreset");
    run_frame(8, 2, 2, 100, 100, 1'b1, -1, -1, fin);
    check_frame_counts("after_reset", 16, 2);
  endtask

  task automatic test_nfft_zero();
    logic hs;
    cfg_nfft = '0; cfg_cp_len = CP_W'(2); cfg_num_symbols = 16'd2;
    clear_counts();
    cycle(1'b1, 1'b1, 32'h1234_5678, 1'b1, hs);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, $urandom, 1'b0, hs);
    total++;
    if (n_out != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL nfft0 got out=%0d busy=%b exp 0/0", n_out, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_large();
    test_cp_zero();
    test_backpressure();
    test_midstart_reset();
    test_nfft_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
